// File: rtl/i_fetch.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID latch with the fetched word and its next-PC.
module i_fetch #(
  parameter int unsigned MEM_DEPTH = 128,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] ex_npc,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 1);

  logic [31:0] pc;
  logic [31:0] pc_next_seq;

  assign pc_next_seq = (pc + 32'd1) & PC_MASK;
  assign mem_addr    = pc;

  // Priority: reset, branch redirect, stall+flush, stall, flush, normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC & PC_MASK;
      if_id_instr <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (pc_src) begin
      pc          <= ex_npc & PC_MASK;
      if_id_instr <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else if (stall && flush) begin
      if_id_instr <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
    end else if (flush) begin
      pc          <= pc_next_seq;
      if_id_instr <= '0;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_next_seq;
      if_id_instr <= mem_data;
      if_id_npc   <= pc_next_seq;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
